// File: rtl/daq_pkt_pkg.sv
// Shared constants, FSM encoding and INFO-word packing for the DAQ packetizer.
package daq_pkt_pkg;

  localparam logic [15:0] MAGIC_WORD = 16'hA55A;
  localparam logic [15:0] DROP_MAX   = 16'hFFFF;

  // INFO word layout: [15:13] oversampling code, [12:8] NCH-1, [7:0] FRAMES-1
  localparam int INFO_OS_LSB  = 13;
  localparam int INFO_NCH_LSB = 8;
  localparam int INFO_FR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_INFO = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  function automatic logic [15:0] make_info(input logic [2:0] os,
                                            input logic [4:0] nch_m1,
                                            input logic [7:0] fr_m1);
    return (16'(os) << INFO_OS_LSB) | (16'(nch_m1) << INFO_NCH_LSB) |
           (16'(fr_m1) << INFO_FR_LSB);
  endfunction

endpackage

// File: rtl/daq_frame_buf2.sv
// Two-entry frame FIFO. Exposes both the head and the entry behind it so the
// packetizer can look one frame ahead and stream across frames without a bubble.
module daq_frame_buf2 #(
  parameter int W = 128
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] second_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;

  // Storage, pointers and occupancy; a push into a full buffer is only issued
  // together with a pop, in which case it lands in the slot being released.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_i) rd_ptr <= ~rd_ptr;
      case ({push_i, pop_i})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_o   = mem[rd_ptr];
  assign second_o = mem[~rd_ptr];
  assign full_o   = (count == 2'd2);
  assign empty_o  = (count == 2'd0);

endmodule

// File: rtl/daq_packetizer_mc.sv
// Multi-channel DAQ packetizer: buffers simultaneous-sample frames and emits
// MAGIC / SEQ / INFO / samples / CSUM packets on a registered valid/ready stream.
module daq_packetizer_mc import daq_pkt_pkg::*; #(
  parameter int          NCH    = 8,
  parameter int          DATA_W = 16,
  parameter int          FRAMES = 4,
  parameter logic [15:0] MAGIC  = MAGIC_WORD
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic [2:0]            os_sel_i,
  input  logic                  frame_valid_i,
  input  logic [NCH*DATA_W-1:0] frame_data_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int FW   = NCH * DATA_W;
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FR_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [FR_W-1:0]   fr_reg, fr_next;
  logic [15:0]       seq_reg;
  logic [2:0]        os_reg;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic              out_valid_reg, out_valid_next;
  logic              out_last_reg, out_last_next;
  logic              overrun_reg;
  logic [15:0]       drop_reg;

  logic [FW-1:0]     buf_head, buf_second, look_data;
  logic              buf_full, buf_empty, look_avail;
  logic              xfer, last_ch, last_fr, pop, push, drop;
  logic [DATA_W-1:0] look_samples [NCH];

  assign xfer    = out_valid_reg & out_ready_i;
  assign last_ch = (ch_reg == CH_W'(NCH - 1));
  assign last_fr = (fr_reg == FR_W'(FRAMES - 1));
  // A frame slot is released as soon as its last channel is handed to the sink.
  assign pop     = xfer & (state_reg == ST_DATA) & last_ch;
  assign push    = frame_valid_i & enable_i & (~buf_full | pop);
  assign drop    = frame_valid_i & enable_i & buf_full & ~pop;

  daq_frame_buf2 #(.W(FW)) u_buf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (frame_data_i),
    .head_o      (buf_head),
    .second_o    (buf_second),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  // Frame that will sit at the buffer head after this edge's push/pop.
  always_comb begin
    look_data  = frame_data_i;
    look_avail = push;
    if (pop) begin
      if (buf_full) begin
        look_data  = buf_second;
        look_avail = 1'b1;
      end
    end else if (!buf_empty) begin
      look_data  = buf_head;
      look_avail = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign look_samples[gi] = look_data[gi*DATA_W +: DATA_W];
  end

  // State, counters, sequence, checksum and drop accounting registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= ST_IDLE;
      ch_reg      <= '0;
      fr_reg      <= '0;
      seq_reg     <= 16'd0;
      os_reg      <= 3'd0;
      acc_reg     <= '0;
      overrun_reg <= 1'b0;
      drop_reg    <= 16'd0;
    end else begin
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      fr_reg      <= fr_next;
      acc_reg     <= acc_next;
      overrun_reg <= drop;
      if (state_reg == ST_IDLE && state_next == ST_HDR) os_reg <= os_sel_i;
      if (state_reg == ST_CSUM && xfer) seq_reg <= seq_reg + 16'd1;
      if (drop && drop_reg != DROP_MAX) drop_reg <= drop_reg + 16'd1;
    end
  end

  // Next state and channel/frame walk; every step waits for a transfer.
  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    fr_next    = fr_reg;
    case (state_reg)
      ST_IDLE: if (enable_i && !buf_empty) state_next = ST_HDR;
      ST_HDR:  if (xfer) state_next = ST_SEQ;
      ST_SEQ:  if (xfer) state_next = ST_INFO;
      ST_INFO: begin
        if (xfer) begin
          state_next = ST_DATA;
          ch_next    = '0;
          fr_next    = '0;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (last_ch) begin
            ch_next = '0;
            if (last_fr) begin
              fr_next    = '0;
              state_next = ST_CSUM;
            end else begin
              fr_next = fr_reg + FR_W'(1);
            end
          end else begin
            ch_next = ch_reg + CH_W'(1);
          end
        end
      end
      ST_CSUM: if (xfer) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Running sum of every word sent so far in the packet, cleared while idle.
  always_comb begin
    acc_next = acc_reg;
    if (state_reg == ST_IDLE) acc_next = '0;
    else if (xfer && state_reg != ST_CSUM) acc_next = acc_reg + out_data_reg;
  end

  // Word to present after the edge; unchanged inputs reproduce the held word.
  always_comb begin
    out_valid_next = 1'b0;
    out_data_next  = '0;
    out_last_next  = 1'b0;
    case (state_next)
      ST_HDR: begin
        out_valid_next = 1'b1;
        out_data_next  = DATA_W'(MAGIC);
      end
      ST_SEQ: begin
        out_valid_next = 1'b1;
        out_data_next  = DATA_W'(seq_reg);
      end
      ST_INFO: begin
        out_valid_next = 1'b1;
        out_data_next  = DATA_W'(make_info(os_reg, 5'(NCH - 1), 8'(FRAMES - 1)));
      end
      ST_DATA: begin
        out_valid_next = look_avail;
        out_data_next  = look_avail ? look_samples[ch_next] : '0;
      end
      ST_CSUM: begin
        out_valid_next = 1'b1;
        out_data_next  = acc_next;
        out_last_next  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered stream outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign out_data_o  = out_data_reg;
  assign out_valid_o = out_valid_reg;
  assign out_last_o  = out_last_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign overrun_o   = overrun_reg;
  assign drop_cnt_o  = drop_reg;

endmodule

// File: tb/tb_daq_packetizer_mc.sv
// Directed bench for daq_packetizer_mc with NCH=4, DATA_W=16, FRAMES=2.
module tb_daq_packetizer_mc;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int FR  = 2;

  localparam logic [63:0] F1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] F2 = {16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [63:0] F3 = {16'd12, 16'd11, 16'd10, 16'd9};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    os_sel = 3'd0;
  logic          frame_valid = 1'b0;
  logic [63:0]   frame_data = 64'd0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          overrun;
  logic [15:0]   drop_cnt;

  int tests = 0;
  int fails = 0;

  logic [16:0] cap_q [$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic        prev_last = 1'b0;
  int          stall_viol = 0;
  int          ovr_seen = 0;

  always #5 clk = ~clk;

  daq_packetizer_mc #(.NCH(NCH), .DATA_W(DW), .FRAMES(FR), .MAGIC(16'hA55A)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .enable_i      (enable),
    .os_sel_i      (os_sel),
    .frame_valid_i (frame_valid),
    .frame_data_i  (frame_data),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_last_o    (out_last),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .drop_cnt_o    (drop_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Expected word idx of a packet carrying samples 1..8: {last, data}.
  function automatic logic [16:0] exp_word(int idx, logic [15:0] seq,
                                           logic [15:0] info, logic [15:0] csum);
    if (idx == 0) return {1'b0, 16'hA55A};
    if (idx == 1) return {1'b0, seq};
    if (idx == 2) return {1'b0, info};
    if (idx <= 10) return {1'b0, 16'(idx - 2)};
    return {1'b1, csum};
  endfunction

  function automatic logic [16:0] cap_at(int i);
    if (i < cap_q.size()) return cap_q[i];
    return 17'bx;
  endfunction

  // One clock: drive inputs at the falling edge, record the word the next
  // rising edge will transfer, and track hold behaviour during stalls.
  task automatic tick(input bit fv, input logic [63:0] fd, input int rmode);
    @(negedge clk);
    if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
      stall_viol++;
    frame_valid = fv;
    frame_data  = fd;
    case (rmode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (out_valid === 1'b1 && out_ready) cap_q.push_back({out_last, out_data});
    prev_stall = (out_valid === 1'b1) && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (overrun === 1'b1) ovr_seen++;
  endtask

  task automatic run_until(input int n, input int rmode, input int maxc);
    int c = 0;
    while (cap_q.size() < n && c < maxc) begin
      tick(1'b0, 64'd0, rmode);
      c++;
    end
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    enable      = 1'b0;
    frame_valid = 1'b0;
    frame_data  = 64'd0;
    out_ready   = 1'b0;
    os_sel      = 3'd0;
    repeat (3) @(negedge clk);
    reset_n    = 1'b1;
    prev_stall = 1'b0;
    cap_q.delete();
    ovr_seen   = 0;
    stall_viol = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_stream: got v=%b d=%h l=%b expected v=0 d=0000 l=0", out_valid, out_data, out_last);
    end
    tests++;
    if (busy !== 1'b0 || overrun !== 1'b0 || drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_status: got busy=%b ovr=%b drop=%h expected 0 0 0000", busy, overrun, drop_cnt);
    end
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_basic();
    apply_reset();
    enable = 1'b1;
    os_sel = 3'b010;
    tick(1'b1, F1, 1);
    tick(1'b1, F2, 1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency_early: got valid=%b expected 0", out_valid);
    end
    tick(1'b0, 64'd0, 1);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'hA55A || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency: got v=%b d=%h busy=%b expected v=1 d=a55a busy=1", out_valid, out_data, busy);
    end
    run_until(12, 1, 100);
    tests++;
    if (cap_q.size() != 12) begin
      fails++;
      $display("FAIL basic_count: got %0d words expected 12", cap_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(i) !== exp_word(i, 16'h0000, 16'h4301, 16'hE87F)) begin
        fails++;
        $display("FAIL basic_word%0d: got %h expected %h", i, cap_at(i), exp_word(i, 16'h0000, 16'h4301, 16'hE87F));
      end
    end
    repeat (3) tick(1'b0, 64'd0, 1);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_after: got busy=%b v=%b expected 0 0", busy, out_valid);
    end
    $display("[TB] basic: %0d words captured", cap_q.size());
  endtask

  task automatic test_random_ready();
    apply_reset();
    enable = 1'b1;
    os_sel = 3'b010;
    tick(1'b1, F1, 2);
    tick(1'b1, F2, 2);
    run_until(12, 2, 400);
    tests++;
    if (cap_q.size() != 12) begin
      fails++;
      $display("FAIL random_count: got %0d words expected 12", cap_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(i) !== exp_word(i, 16'h0000, 16'h4301, 16'hE87F)) begin
        fails++;
        $display("FAIL random_word%0d: got %h expected %h", i, cap_at(i), exp_word(i, 16'h0000, 16'h4301, 16'hE87F));
      end
    end
    tests++;
    if (stall_viol != 0) begin
      fails++;
      $display("FAIL random_stall_hold: got %0d violations expected 0", stall_viol);
    end
    $display("[TB] random_ready: %0d words captured", cap_q.size());
  endtask

  task automatic test_overrun();
    apply_reset();
    enable = 1'b1;
    os_sel = 3'b010;
    tick(1'b1, F1, 0);
    tick(1'b1, F2, 0);
    tick(1'b1, F3, 0);
    repeat (4) tick(1'b0, 64'd0, 0);
    tests++;
    if (ovr_seen != 1) begin
      fails++;
      $display("FAIL overrun_pulses: got %0d expected 1", ovr_seen);
    end
    tests++;
    if (drop_cnt !== 16'd1) begin
      fails++;
      $display("FAIL overrun_drop_cnt: got %h expected 0001", drop_cnt);
    end
    tests++;
    if (cap_q.size() != 0) begin
      fails++;
      $display("FAIL overrun_no_xfer: got %0d words expected 0", cap_q.size());
    end
    run_until(12, 1, 100);
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(i) !== exp_word(i, 16'h0000, 16'h4301, 16'hE87F)) begin
        fails++;
        $display("FAIL overrun_word%0d: got %h expected %h", i, cap_at(i), exp_word(i, 16'h0000, 16'h4301, 16'hE87F));
      end
    end
    repeat (20) tick(1'b0, 64'd0, 1);
    tests++;
    if (cap_q.size() != 12 || busy !== 1'b0) begin
      fails++;
      $display("FAIL overrun_no_extra: got %0d words busy=%b expected 12 busy=0", cap_q.size(), busy);
    end
    $display("[TB] overrun: drop_cnt=%h", drop_cnt);
  endtask

  task automatic test_os_sel();
    int c;
    apply_reset();
    enable = 1'b1;
    os_sel = 3'b010;
    tick(1'b1, F1, 1);
    tick(1'b1, F2, 1);
    c = 0;
    while (cap_q.size() < 12 && c < 100) begin
      tick(1'b0, 64'd0, 1);
      if (cap_q.size() >= 5) os_sel = 3'b111;
      c++;
    end
    tick(1'b1, F1, 1);
    tick(1'b1, F2, 1);
    run_until(24, 1, 100);
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(i) !== exp_word(i, 16'h0000, 16'h4301, 16'hE87F)) begin
        fails++;
        $display("FAIL os_pkt0_word%0d: got %h expected %h", i, cap_at(i), exp_word(i, 16'h0000, 16'h4301, 16'hE87F));
      end
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(12 + i) !== exp_word(i, 16'h0001, 16'hE301, 16'h8880)) begin
        fails++;
        $display("FAIL os_pkt1_word%0d: got %h expected %h", i, cap_at(12 + i), exp_word(i, 16'h0001, 16'hE301, 16'h8880));
      end
    end
    $display("[TB] os_sel: %0d words captured", cap_q.size());
  endtask

  task automatic test_gap();
    apply_reset();
    enable = 1'b1;
    os_sel = 3'b010;
    tick(1'b1, F1, 1);
    repeat (40) tick(1'b0, 64'd0, 1);
    tests++;
    if (cap_q.size() != 7 || out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL gap_stall: got %0d words v=%b busy=%b expected 7 v=0 busy=1", cap_q.size(), out_valid, busy);
    end
    tick(1'b1, F2, 1);
    run_until(12, 1, 100);
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(i) !== exp_word(i, 16'h0000, 16'h4301, 16'hE87F)) begin
        fails++;
        $display("FAIL gap_word%0d: got %h expected %h", i, cap_at(i), exp_word(i, 16'h0000, 16'h4301, 16'hE87F));
      end
    end
    $display("[TB] gap: %0d words captured", cap_q.size());
  endtask

  task automatic test_reset_mid();
    apply_reset();
    enable = 1'b1;
    os_sel = 3'b010;
    tick(1'b1, F1, 0);
    tick(1'b1, F2, 0);
    tick(1'b1, F3, 0);
    run_until(12, 1, 100);
    tests++;
    if (drop_cnt !== 16'd1) begin
      fails++;
      $display("FAIL rstmid_pre_drop: got %h expected 0001", drop_cnt);
    end
    tick(1'b1, F1, 1);
    tick(1'b1, F2, 1);
    run_until(17, 1, 50);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_async: got v=%b busy=%b drop=%h expected 0 0 0000", out_valid, busy, drop_cnt);
    end
    frame_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    prev_stall = 1'b0;
    cap_q.delete();
    tick(1'b1, F1, 1);
    tick(1'b1, F2, 1);
    run_until(12, 1, 100);
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(i) !== exp_word(i, 16'h0000, 16'h4301, 16'hE87F)) begin
        fails++;
        $display("FAIL rstmid_word%0d: got %h expected %h", i, cap_at(i), exp_word(i, 16'h0000, 16'h4301, 16'hE87F));
      end
    end
    tests++;
    if (drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_post_drop: got %h expected 0000", drop_cnt);
    end
    $display("[TB] reset_mid: %0d words captured", cap_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_overrun();
    test_os_sel();
    test_gap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
